// File: rtl/matmul_pkg.sv
// ---------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the UART matrix-loading front end:
//   state_e           - loader FSM state encoding (3 bits)
//   DEFAULT_SYNC_BYTE - frame header byte value (8'hA5)
//   elem_count()      - number of elements in an n x n matrix
// ---------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4
    } state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic int unsigned elem_count(input int unsigned n);
        return n * n;
    endfunction

endpackage

// File: rtl/rx_timeout_ctr.sv
// ---------------------------------------------------------------------------
// rx_timeout_ctr
// Counts idle cycles between received bytes while a frame is being loaded.
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   enable  in  counting allowed (loader is in a LOAD state); count held at 0
//               otherwise
//   clear   in  a byte arrived this cycle; restarts the count
//   expired out one-cycle pulse in the cycle the count reaches TIMEOUT_CYC
// ---------------------------------------------------------------------------
module rx_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    // The count would become TIMEOUT_CYC on this edge; a byte arriving in the
    // same cycle wins, so clear suppresses the pulse.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = enable && !clear && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!enable || clear || expired) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_matrix_loader.sv
// ---------------------------------------------------------------------------
// uart_matrix_loader
// Frame controller between uart_rx and the matrix-multiply engine. Waits for a
// sync byte, writes N*N bytes into the A buffer then N*N bytes into the B
// buffer, pulses start and waits for compute_done.
//   clk          in  baud-rate clock shared with uart_rx
//   rst          in  synchronous active-high reset
//   rx_data      in  received byte, valid while rx_valid=1
//   rx_valid     in  one-cycle pulse per received byte
//   compute_done in  one-cycle completion pulse from the matmul engine
//   mat_we       out buffer write enable pulse
//   mat_sel      out 0 = A buffer, 1 = B buffer
//   mat_addr     out row-major element index
//   mat_wdata    out element value
//   start        out one-cycle launch pulse to the engine
//   busy         out high whenever the loader is not idle
//   done         out one-cycle pulse when a frame completes
//   frame_err    out one-cycle pulse on an inter-byte timeout abort
//   overrun      out one-cycle pulse when a byte is dropped in START/WAIT
// ---------------------------------------------------------------------------
module uart_matrix_loader
    import matmul_pkg::*;
#(
    parameter int unsigned N           = 2,
    parameter int unsigned ADDR_W      = 2,
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              compute_done,
    output logic              mat_we,
    output logic              mat_sel,
    output logic [ADDR_W-1:0] mat_addr,
    output logic [7:0]        mat_wdata,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned       NN       = elem_count(N);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NN - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              mat_we_q;
    logic              mat_sel_q;
    logic [ADDR_W-1:0] mat_addr_q;
    logic [7:0]        mat_wdata_q;
    logic              start_q;
    logic              busy_q;
    logic              done_q;
    logic              frame_err_q;
    logic              overrun_q;

    logic load_active;
    logic expired;

    assign load_active = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);

    rx_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (load_active),
        .clear   (rx_valid),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            mat_we_q    <= 1'b0;
            mat_sel_q   <= 1'b0;
            mat_addr_q  <= '0;
            mat_wdata_q <= 8'h00;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // Pulse outputs default low; address/data hold their last value.
            mat_we_q    <= 1'b0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state_q <= ST_LOAD_A;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                ST_LOAD_A, ST_LOAD_B: begin
                    if (rx_valid) begin
                        // Every byte here is payload, sync value included.
                        mat_we_q    <= 1'b1;
                        mat_sel_q   <= (state_q == ST_LOAD_B);
                        mat_addr_q  <= idx_q;
                        mat_wdata_q <= rx_data;
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_START;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (expired) begin
                        state_q     <= ST_IDLE;
                        idx_q       <= '0;
                        busy_q      <= 1'b0;
                        frame_err_q <= 1'b1;
                    end
                end

                ST_START: begin
                    start_q <= 1'b1;
                    state_q <= ST_WAIT;
                    if (rx_valid) begin
                        overrun_q <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (rx_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (compute_done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mat_we    = mat_we_q;
    assign mat_sel   = mat_sel_q;
    assign mat_addr  = mat_addr_q;
    assign mat_wdata = mat_wdata_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
